// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file and its scoreboard:
//   - default data width / register count
//   - reg_addr_t / xword_t for the default configuration
//   - wr_winner(): resolves which write port (if any) targets an address,
//     highest-index port winning. Used by both the write path and the bypass
//     path so the two can never disagree on the winner.
// wr_winner works on vectors widened to MAX_NWR ports of MAX_AW bits so one
// non-parametric function serves every legal configuration; callers
// zero-extend their narrower vectors and tie off unused ports.
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    localparam int MAX_NWR = 2;
    localparam int MAX_AW  = 16;

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

    typedef struct packed {
        logic       hit;
        logic [0:0] port;
    } wr_win_t;

    function automatic wr_win_t wr_winner(
        input logic [MAX_AW-1:0]         addr,
        input logic [MAX_NWR-1:0]        wr_en,
        input logic [MAX_NWR*MAX_AW-1:0] wr_addr
    );
        wr_win_t r;
        r.hit  = 1'b0;
        r.port = 1'b0;
        // Ascending scan: a later (higher-index) match overrides an earlier one.
        for (int w = 0; w < MAX_NWR; w++) begin
            if (wr_en[w] && (wr_addr[w*MAX_AW +: MAX_AW] == addr)) begin
                r.hit  = 1'b1;
                r.port = 1'(w);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
// Busy-bit array tracking registers with an outstanding producer.
//   clk, rst            : clock, async active-high reset (clears all bits)
//   iss_en, iss_addr    : issue marks iss_addr busy
//   wr_en, wr_addr,
//   wr_clr              : writeback clears busy of wr_addr when wr_en & wr_clr
//   flush               : clears every busy bit, overrides a same-cycle issue
//   busy_vec            : registered busy bits, bit i = register i
// ----------------------------------------------------------------------------
module regfile_scoreboard
#(
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR-1:0]    wr_clr,
    input  logic              flush,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next busy state: clears applied before the issue so a same-cycle
    // issue to the same register wins (new producer supersedes the old).
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && wr_clr[w]) begin
                    busy_d[wr_addr[w*AW +: AW]] = 1'b0;
                end else begin
                    busy_d = busy_d;
                end
            end
            if (iss_en) begin
                busy_d[iss_addr] = 1'b1;
            end else begin
                busy_d = busy_d;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
    end

    // Busy-bit register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// ----------------------------------------------------------------------------
// regfile_mp_sb
// Multi-port integer register file with integrated busy-bit scoreboard.
//   clk, rst           : clock, async active-high reset (data and busy -> 0)
//   rd_addr/rd_data    : NRD combinational read ports, packed per port
//   rd_busy            : busy flag of each addressed register
//   wr_en/wr_addr/
//   wr_data/wr_clr     : NWR write ports; wr_clr also clears the busy bit
//   iss_en/iss_addr    : mark a destination register busy
//   flush              : clear all busy bits (data untouched)
//   busy_vec           : registered busy bits
// BYPASS=1 forwards same-cycle write data / busy-clear to the read ports.
// ZERO_REG=1 makes register 0 read as zero, drop writes and never be busy.
// ----------------------------------------------------------------------------
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NWR-1:0]      wr_clr,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    logic [MAX_NWR-1:0]        wen_x_s;
    logic [MAX_NWR*MAX_AW-1:0] waddr_x_s;
    logic [XLEN-1:0]           wdata_lo_s;
    logic [XLEN-1:0]           wdata_hi_s;

    wr_win_t         reg_win_s    [NREGS];
    logic [AW-1:0]   rd_a_s       [NRD];
    wr_win_t         rd_win_s     [NRD];
    logic            rd_clr_hit_s [NRD];

    // Port 0 data, and data of the highest port (equals port 0 when NWR=1).
    assign wdata_lo_s = wr_data[XLEN-1:0];
    assign wdata_hi_s = wr_data[NWR*XLEN-1 -: XLEN];

    // Widen write enables/addresses to the shape wr_winner expects.
    always_comb begin
        wen_x_s   = '0;
        waddr_x_s = '0;
        for (int w = 0; w < NWR; w++) begin
            wen_x_s[w]                        = wr_en[w];
            waddr_x_s[w*MAX_AW +: MAX_AW]     = MAX_AW'(wr_addr[w*AW +: AW]);
        end
    end

    // Per-register write winner.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            reg_win_s[i] = wr_winner(MAX_AW'(i), wen_x_s, waddr_x_s);
        end
    end

    // Next register contents; writes to register 0 dropped when hardwired.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            if (reg_win_s[i].hit && !((ZERO_REG != 0) && (i == 0))) begin
                regs_d[i] = reg_win_s[i].port[0] ? wdata_hi_s : wdata_lo_s;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Data array with asynchronous clear; writes in a reset cycle are lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Per read port: address, bypass winner and busy-clear hit (any clearing port).
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd_a_s[p]       = rd_addr[p*AW +: AW];
            rd_win_s[p]     = wr_winner(MAX_AW'(rd_addr[p*AW +: AW]), wen_x_s, waddr_x_s);
            rd_clr_hit_s[p] = 1'b0;
            for (int w = 0; w < NWR; w++) begin
                rd_clr_hit_s[p] = rd_clr_hit_s[p]
                                | (wr_en[w] & wr_clr[w] & (wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW]));
            end
        end
    end

    // Read muxes. Bypass is suppressed during reset so reads show the
    // cleared array rather than a write that is about to be discarded.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            if ((ZERO_REG != 0) && (rd_a_s[p] == '0)) begin
                rd_data[p*XLEN +: XLEN] = '0;
                rd_busy[p]              = 1'b0;
            end else begin
                if ((BYPASS != 0) && !rst && rd_win_s[p].hit) begin
                    rd_data[p*XLEN +: XLEN] = rd_win_s[p].port[0] ? wdata_hi_s : wdata_lo_s;
                end else begin
                    rd_data[p*XLEN +: XLEN] = regs_q[rd_a_s[p]];
                end
                if ((BYPASS != 0) && rd_clr_hit_s[p]) begin
                    rd_busy[p] = 1'b0;
                end else begin
                    rd_busy[p] = busy_vec[rd_a_s[p]];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .AW       (AW),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_clr   (wr_clr),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp_sb
// Two instances share every input: dut_a (BYPASS=1, ZERO_REG=1) and
// dut_b (BYPASS=0, ZERO_REG=0), both with two write ports. A behavioural
// model (plain arrays, index 0 = config A, 1 = config B) predicts reads,
// busy flags and busy_vec for directed scenarios and random traffic.
// ----------------------------------------------------------------------------
module tb_regfile_mp_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [2*AW-1:0]     rd_addr;
    logic [2*XLEN-1:0]   rd_data_a, rd_data_b;
    logic [1:0]          rd_busy_a, rd_busy_b;
    logic [1:0]          wr_en;
    logic [2*AW-1:0]     wr_addr;
    logic [2*XLEN-1:0]   wr_data;
    logic [1:0]          wr_clr;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;
    logic [NREGS-1:0]    busy_vec_a, busy_vec_b;

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec_a)
    );

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .NWR(2), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec_b)
    );

    // Model state: [0] = bypass + hardwired zero, [1] = neither.
    logic [XLEN-1:0] mem_m  [2][NREGS];
    logic            busy_m [2][NREGS];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [AW-1:0] wa(input int w);
        return wr_addr[w*AW +: AW];
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input int m, input int p);
        logic [AW-1:0]   a;
        logic [XLEN-1:0] v;
        a = rd_addr[p*AW +: AW];
        if (m == 0 && a == 0) return '0;
        v = mem_m[m][a];
        if (m == 0 && !rst)
            for (int w = 0; w < 2; w++)
                if (wr_en[w] && wa(w) == a) v = wr_data[w*XLEN +: XLEN];
        return v;
    endfunction

    function automatic logic exp_busy(input int m, input int p);
        logic [AW-1:0] a;
        logic          b;
        a = rd_addr[p*AW +: AW];
        if (m == 0 && a == 0) return 1'b0;
        b = busy_m[m][a];
        if (m == 0)
            for (int w = 0; w < 2; w++)
                if (wr_en[w] && wr_clr[w] && wa(w) == a) b = 1'b0;
        return b;
    endfunction

    function automatic logic [NREGS-1:0] exp_vec(input int m);
        logic [NREGS-1:0] v;
        for (int i = 0; i < NREGS; i++) v[i] = busy_m[m][i];
        return v;
    endfunction

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 2; p++) begin
                check($sformatf("rd_data cfg%0d port%0d addr%0d", m, p, rd_addr[p*AW +: AW]),
                      (m == 0) ? rd_data_a[p*XLEN +: XLEN] : rd_data_b[p*XLEN +: XLEN],
                      exp_data(m, p));
                check($sformatf("rd_busy cfg%0d port%0d addr%0d", m, p, rd_addr[p*AW +: AW]),
                      32'((m == 0) ? rd_busy_a[p] : rd_busy_b[p]),
                      32'(exp_busy(m, p)));
            end
            check($sformatf("busy_vec cfg%0d", m),
                  (m == 0) ? busy_vec_a : busy_vec_b, exp_vec(m));
        end
    endtask

    task automatic model_update();
        for (int m = 0; m < 2; m++) begin
            for (int w = 0; w < 2; w++)
                if (wr_en[w]) mem_m[m][wa(w)] = wr_data[w*XLEN +: XLEN];
            if (m == 0) mem_m[m][0] = '0;
            if (flush) begin
                for (int i = 0; i < NREGS; i++) busy_m[m][i] = 1'b0;
            end else begin
                for (int w = 0; w < 2; w++)
                    if (wr_en[w] && wr_clr[w]) busy_m[m][wa(w)] = 1'b0;
                if (iss_en) busy_m[m][iss_addr] = 1'b1;
            end
            if (m == 0) busy_m[m][0] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < NREGS; i++) begin
                mem_m[m][i]  = '0;
                busy_m[m][i] = 1'b0;
            end
    endtask

    task automatic idle();
        wr_en    = 2'b00;
        wr_addr  = '0;
        wr_data  = '0;
        wr_clr   = 2'b00;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
    endtask

    // Called at a falling edge with inputs set: check, advance model, next falling edge.
    task automatic step();
        #1;
        check_all();
        model_update();
        @(negedge clk);
    endtask

    initial begin
        idle();
        rd_addr = '0;
        rst     = 1'b1;
        model_reset();
        #2;
        for (int a = 0; a < NREGS; a++) begin
            rd_addr = {5'(NREGS - 1 - a), 5'(a)};
            #1;
            check_all();
        end
        @(negedge clk);
        rst = 1'b0;

        // Reset asserted in the middle of a write to x5.
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd5};
        wr_data = {32'h0, 32'hDEADBEEF};
        rd_addr = {5'd5, 5'd5};
        #1;
        check_all();
        rst = 1'b1;
        #1;
        check("rst_mid_write_byp", rd_data_a[31:0], 32'h0);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("x5_after_rst_a", rd_data_a[31:0], 32'h0);
        check("x5_after_rst_b", rd_data_b[31:0], 32'h0);
        step();

        // Same-cycle write/read of x7.
        wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'h12345678};
        rd_addr = {5'd0, 5'd7};
        #1;
        check("x7_byp_a", rd_data_a[31:0], 32'h12345678);
        check("x7_nobyp_b", rd_data_b[31:0], 32'h0);
        step();
        idle();
        #1;
        check("x7_next_b", rd_data_b[31:0], 32'h12345678);
        step();

        // Dual write to x3: port 1 wins.
        wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h5555FFFF, 32'hAAAA0000};
        rd_addr = {5'd3, 5'd3};
        #1;
        check("x3_dual_byp_a", rd_data_a[63:32], 32'h5555FFFF);
        step();
        idle();
        #1;
        check("x3_dual_a", rd_data_a[31:0], 32'h5555FFFF);
        check("x3_dual_b", rd_data_b[31:0], 32'h5555FFFF);
        step();

        // Write and issue x0.
        wr_en = 2'b01; wr_addr = '0; wr_data = {32'h0, 32'hFFFFFFFF};
        iss_en = 1'b1; iss_addr = 5'd0; rd_addr = '0;
        step();
        idle();
        #1;
        check("x0_zero_a", rd_data_a[31:0], 32'h0);
        check("x0_busy_a", 32'(busy_vec_a[0]), 32'h0);
        check("x0_nozero_b", rd_data_b[31:0], 32'hFFFFFFFF);
        check("x0_busy_b", 32'(busy_vec_b[0]), 32'h1);
        step();

        // Scoreboard on x9.
        iss_en = 1'b1; iss_addr = 5'd9;
        step();
        idle();
        #1;
        check("x9_issued", 32'(busy_vec_a[9]), 32'h1);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h99}; wr_clr = 2'b01;
        iss_en = 1'b1; iss_addr = 5'd9;
        step();
        idle();
        #1;
        check("x9_set_wins", 32'(busy_vec_a[9]), 32'h1);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h9A}; wr_clr = 2'b01;
        rd_addr = {5'd0, 5'd9};
        #1;
        check("x9_rdbusy_byp_a", 32'(rd_busy_a[0]), 32'h0);
        check("x9_rdbusy_nobyp_b", 32'(rd_busy_b[0]), 32'h1);
        step();
        idle();
        #1;
        check("x9_cleared", 32'(busy_vec_a[9]), 32'h0);
        step();

        // Issues then flush with a concurrent issue.
        iss_en = 1'b1; iss_addr = 5'd1;  step();
        iss_en = 1'b1; iss_addr = 5'd2;  step();
        iss_en = 1'b1; iss_addr = 5'd31; step();
        flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd4; step();
        idle();
        rd_addr = {5'd7, 5'd3};
        #1;
        check("flush_vec_a", busy_vec_a, 32'h0);
        check("flush_vec_b", busy_vec_b, 32'h0);
        check("flush_keeps_x3", rd_data_a[31:0], 32'h5555FFFF);
        check("flush_keeps_x7", rd_data_b[63:32], 32'h12345678);
        step();

        // Random traffic, with address collisions biased in.
        for (int c = 0; c < 400; c++) begin
            rd_addr  = 10'($urandom);
            wr_en    = 2'($urandom);
            wr_addr  = 10'($urandom);
            wr_data  = {$urandom, $urandom};
            wr_clr   = 2'($urandom);
            iss_en   = 1'($urandom);
            iss_addr = 5'($urandom);
            flush    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) wr_addr[9:5] = wr_addr[4:0];
            if ($urandom_range(0, 2) == 0) rd_addr[4:0] = wr_addr[4:0];
            if ($urandom_range(0, 2) == 0) rd_addr[9:5] = wr_addr[9:5];
            if ($urandom_range(0, 3) == 0) iss_addr = wr_addr[4:0];
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
